// File: rtl/mult_sched.sv
// mult_sched: arbitrates between two source FIFOs. It reads one operand pair
// at a time, multiplies the 8-bit halves, and writes the 16-bit product with
// its source tag to a result FIFO. It also keeps per-source result counters
// and a sticky flag that records a read whose data never arrived.
module mult_sched #(
    parameter int BURST = 1,   // max back-to-back grants to one source under contention (1..15)
    parameter int CNT_W = 16   // width of the per-source result counters
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EMPTY0,
    input  logic             EMPTY1,
    input  logic             VALID0,
    input  logic             VALID1,
    input  logic [15:0]      DIN0,
    input  logic [15:0]      DIN1,
    output logic             RD0,
    output logic             RD1,
    input  logic             OFULL,
    input  logic             OAFULL,
    output logic             WR_OUT,
    output logic [15:0]      DOUT,
    output logic             TAG,
    output logic [CNT_W-1:0] CNT0,
    output logic [CNT_W-1:0] CNT1,
    output logic             ERR
);

    typedef enum logic [1:0] {IDLE, RDREQ, WAITV, WRITE} state_t;

    localparam logic [3:0] BURST_L = 4'(BURST);

    state_t      state;
    state_t      state_nx;
    logic        last;        // most recently granted source
    logic [3:0]  gcnt;        // consecutive grants to 'last', 0 only before the first grant
    logic        gsel;        // source owning the transaction in flight
    logic [1:0]  wait_cnt;    // WAITV cycles already spent without VALID

    logic        elig0;
    logic        elig1;
    logic        keep;
    logic        grant;
    logic        sel_valid;
    logic [15:0] sel_din;
    logic [15:0] product;

    logic        do_grant;
    logic        do_capture;
    logic        do_timeout;
    logic        do_write;

    assign elig0 = !EMPTY0 && !OAFULL;
    assign elig1 = !EMPTY1 && !OAFULL;

    // Stay with the previous source while its run is short of BURST. Before
    // the first grant gcnt is 0, so a contended start goes to ~last, i.e. source 0.
    assign keep  = (gcnt != 4'd0) && (gcnt != BURST_L);
    assign grant = (elig0 && elig1) ? (keep ? last : ~last) : elig1;

    assign sel_valid = gsel ? VALID1 : VALID0;
    assign sel_din   = gsel ? DIN1   : DIN0;
    assign product   = {8'd0, sel_din[15:8]} * {8'd0, sel_din[7:0]};

    // Next-state decode and one-cycle action strobes for the datapath.
    always_comb begin
        // NOTE: every output of this block is given a default first so no path leaves it unassigned and infers a latch.
        state_nx   = state;
        do_grant   = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        do_write   = 1'b0;
        case (state)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_nx = RDREQ;
                    do_grant = 1'b1;
                end
            end
            RDREQ: state_nx = WAITV;
            WAITV: begin
                if (sel_valid) begin
                    state_nx   = WRITE;
                    do_capture = 1'b1;
                end else if (wait_cnt == 2'd3) begin
                    state_nx   = IDLE;
                    do_timeout = 1'b1;
                end
            end
            WRITE: begin
                if (!OFULL) begin
                    state_nx = IDLE;
                    do_write = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register; a synchronous reset abandons any transaction in flight.
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Registered strobes, arbitration history, captured result, counters and error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RD0      <= 1'b0;
            RD1      <= 1'b0;
            WR_OUT   <= 1'b0;
            DOUT     <= 16'd0;
            TAG      <= 1'b0;
            CNT0     <= '0;
            CNT1     <= '0;
            ERR      <= 1'b0;
            last     <= 1'b1;
            gcnt     <= 4'd0;
            gsel     <= 1'b0;
            wait_cnt <= 2'd0;
        end else begin
            RD0    <= do_grant && !grant;
            RD1    <= do_grant &&  grant;
            WR_OUT <= do_write;

            if (do_grant) begin
                gsel <= grant;
                last <= grant;
                if (grant == last && gcnt != 4'd0)
                    gcnt <= (gcnt < BURST_L) ? gcnt + 4'd1 : gcnt;
                else
                    gcnt <= 4'd1;
            end

            wait_cnt <= (state == WAITV) ? wait_cnt + 2'd1 : 2'd0;

            if (do_capture) begin
                DOUT <= product;
                TAG  <= gsel;
            end

            if (do_timeout) ERR <= 1'b1;

            if (do_write) begin
                if (TAG) CNT1 <= CNT1 + 1'b1;
                else     CNT0 <= CNT0 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched. It drives two instances: u_a with
// BURST=1, CNT_W=16 and u_b with BURST=2, CNT_W=4. Only one instance is active
// at a time; the other is held in reset. Two FIFO behavioural models feed the
// active instance, and a grant-order model predicts every result write.
module tb_mult_sched;

    typedef struct packed { logic tag; logic [15:0] dout; } exp_t;
    typedef struct { logic src; logic [15:0] din; logic [15:0] dout; } vec_t;

    logic        CLK = 1'b0;
    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        empty0 = 1'b1, empty1 = 1'b1, valid0 = 1'b0, valid1 = 1'b0;
    logic [15:0] din0 = 16'd0, din1 = 16'd0;
    logic        ofull = 1'b0, oafull = 1'b1;
    logic        act = 1'b0;

    logic        rd0_a, rd1_a, wr_a, tag_a, err_a;
    logic [15:0] dout_a, cnt0_a, cnt1_a;
    logic        rd0_b, rd1_b, wr_b, tag_b, err_b;
    logic [15:0] dout_b;
    logic [3:0]  cnt0_b, cnt1_b;

    logic        rd0, rd1, wr, tag, err;
    logic [15:0] dout, cnt0, cnt1;

    assign rd0  = act ? rd0_b  : rd0_a;
    assign rd1  = act ? rd1_b  : rd1_a;
    assign wr   = act ? wr_b   : wr_a;
    assign tag  = act ? tag_b  : tag_a;
    assign err  = act ? err_b  : err_a;
    assign dout = act ? dout_b : dout_a;
    assign cnt0 = act ? {12'd0, cnt0_b} : cnt0_a;
    assign cnt1 = act ? {12'd0, cnt1_b} : cnt1_a;

    mult_sched #(.BURST(1), .CNT_W(16)) u_a (
        .CLK(CLK), .RST(rst0), .EMPTY0(empty0), .EMPTY1(empty1),
        .VALID0(valid0), .VALID1(valid1), .DIN0(din0), .DIN1(din1),
        .RD0(rd0_a), .RD1(rd1_a), .OFULL(ofull), .OAFULL(oafull),
        .WR_OUT(wr_a), .DOUT(dout_a), .TAG(tag_a), .CNT0(cnt0_a), .CNT1(cnt1_a), .ERR(err_a)
    );

    mult_sched #(.BURST(2), .CNT_W(4)) u_b (
        .CLK(CLK), .RST(rst1), .EMPTY0(empty0), .EMPTY1(empty1),
        .VALID0(valid0), .VALID1(valid1), .DIN0(din0), .DIN1(din1),
        .RD0(rd0_b), .RD1(rd1_b), .OFULL(ofull), .OAFULL(oafull),
        .WR_OUT(wr_b), .DOUT(dout_b), .TAG(tag_b), .CNT0(cnt0_b), .CNT1(cnt1_b), .ERR(err_b)
    );

    always #5 CLK = ~CLK;

    // Bookkeeping
    int n_tests = 0, n_fail = 0;
    int cyc = 0, last_rd = -100;

    // Reference model state: arbitration history and result counters
    int m_last = -1, m_run = 0, m_cnt0 = 0, m_cnt1 = 0, m_burst = 1, cmask = 65535;

    // FIFO model and read responder controls
    logic [15:0] fmem [2][64];
    int          fhead [2] = '{0, 0};
    int          ftail [2] = '{0, 0};
    int          lat = 1;          // cycles from RD to VALID; 0 means never
    logic        noise = 1'b0;     // pulse the other source's VALID while waiting
    logic        ofull_force = 1'b0, ofull_rand = 1'b0;
    int          pend = 0;
    logic        psrc = 1'b0;
    logic [15:0] pdata = 16'd0;

    exp_t        exp_q [$];
    logic        tag_log [$];
    logic [31:0] lq0 [$], lq1 [$];   // {expected product, data} per source, in FIFO order

    vec_t        vecs [8];
    logic        seq1 [6];
    logic        seq2 [6];

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    function automatic logic [15:0] prod(input logic [15:0] x);
        int a, b;
        a = int'(x) / 256;
        b = int'(x) % 256;
        return 16'(a * b);
    endfunction

    // Arbitration rules: one candidate wins outright; under contention, repeat the
    // previous source until it has BURST grants in a row; the very first contested grant goes to 0.
    task automatic model_grant(input bit e0, input bit e1, output int g);
        if (e0 && e1)
            g = (m_last >= 0 && m_run < m_burst) ? m_last : ((m_last < 0) ? 0 : 1 - m_last);
        else
            g = e0 ? 0 : 1;
        m_run  = (g == m_last) ? ((m_run < m_burst) ? m_run + 1 : m_burst) : 1;
        m_last = g;
    endtask

    task automatic fifo_push(input int s, input logic [15:0] d);
        fmem[s][ftail[s]] = d;
        ftail[s] = (ftail[s] + 1) % 64;
    endtask

    task automatic load(input int s, input logic [15:0] d, input logic [15:0] e);
        fifo_push(s, d);
        if (s == 0) lq0.push_back({e, d});
        else        lq1.push_back({e, d});
    endtask

    // Turn the loaded entries into the expected write stream, in grant order.
    task automatic prep();
        int g;
        logic [31:0] e;
        while (lq0.size() + lq1.size() > 0) begin
            model_grant(lq0.size() > 0, lq1.size() > 0, g);
            if (g == 0) begin e = lq0.pop_front(); m_cnt0++; end
            else        begin e = lq1.pop_front(); m_cnt1++; end
            exp_q.push_back('{tag: g[0], dout: e[31:16]});
        end
    endtask

    task automatic finish_batch();
        int t = 0;
        oafull = 1'b0;
        while ((exp_q.size() != 0 || fhead[0] != ftail[0] || fhead[1] != ftail[1]) && t < 2000) begin
            @(negedge CLK);
            t++;
        end
        check("drain_left", 32'(exp_q.size()), 0);
        repeat (3) @(negedge CLK);
        oafull = 1'b1;
        check("cnt0", 32'(cnt0), 32'(m_cnt0 & cmask));
        check("cnt1", 32'(cnt1), 32'(m_cnt1 & cmask));
    endtask

    task automatic do_reset();
        if (act) rst1 = 1'b1; else rst0 = 1'b1;
        repeat (2) @(negedge CLK);
        rst0 = act ? 1'b1 : 1'b0;
        rst1 = act ? 1'b0 : 1'b1;
        m_last = -1; m_run = 0; m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic check_reset(input string p);
        check({p, "_rd0"},  32'(rd0),  0);
        check({p, "_rd1"},  32'(rd1),  0);
        check({p, "_wr"},   32'(wr),   0);
        check({p, "_dout"}, 32'(dout), 0);
        check({p, "_tag"},  32'(tag),  0);
        check({p, "_cnt0"}, 32'(cnt0), 0);
        check({p, "_cnt1"}, 32'(cnt1), 0);
        check({p, "_err"},  32'(err),  0);
    endtask

    task automatic rand_batch();
        int n0 = $urandom_range(0, 4);
        int n1 = $urandom_range(0, 4);
        logic [15:0] d;
        lat = $urandom_range(1, 4);
        noise = 1'($urandom_range(0, 1));
        ofull_rand = 1'b1;
        for (int i = 0; i < n0; i++) begin d = 16'($urandom); load(0, d, prod(d)); end
        for (int i = 0; i < n1; i++) begin d = 16'($urandom); load(1, d, prod(d)); end
        prep();
        finish_batch();
        ofull_rand = 1'b0;
        noise = 1'b0;
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // FIFO model: pops on RD, returns VALID 'lat' cycles later, optionally
    // pulses the other source's VALID with junk data while the read is pending.
    always @(negedge CLK) begin : resp
        int s;
        valid0 = 1'b0;
        valid1 = 1'b0;
        din0 = 16'($urandom);
        din1 = 16'($urandom);
        if (pend > 0) begin
            pend--;
            if (noise) begin
                if (psrc) valid0 = 1'b1; else valid1 = 1'b1;
            end
            if (pend == 0) begin
                if (psrc) begin valid1 = 1'b1; din1 = pdata; end
                else      begin valid0 = 1'b1; din0 = pdata; end
            end
        end
        if (rd0 || rd1) begin
            s = rd1 ? 1 : 0;
            psrc = rd1;
            pdata = fmem[s][fhead[s]];
            fhead[s] = (fhead[s] + 1) % 64;
            pend = lat;
        end
        empty0 = (fhead[0] == ftail[0]);
        empty1 = (fhead[1] == ftail[1]);
        ofull = ofull_force | (ofull_rand & 1'($urandom_range(0, 1)));
    end

    // Write scoreboard and strobe protocol checks
    always @(negedge CLK) begin : mon
        if (wr) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(wr), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_tag",  32'(tag),  32'(e.tag));
                check("wr_dout", 32'(dout), 32'(e.dout));
                tag_log.push_back(tag);
            end
        end
        if (rd0 || rd1) begin
            check("rd_onehot",   32'(rd0 & rd1), 0);
            check("rd_wr_excl",  32'(wr), 0);
            check("rd_interval", 32'((cyc - last_rd) >= 4), 1);
            last_rd = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t, r, w;
        logic any_rd;
        logic [15:0] d;

        vecs[0] = '{1'b0, 16'h0304, 16'h000C};
        vecs[1] = '{1'b1, 16'hFFFF, 16'hFE01};
        vecs[2] = '{1'b0, 16'h00FF, 16'h0000};
        vecs[3] = '{1'b1, 16'h0101, 16'h0001};
        vecs[4] = '{1'b0, 16'h8002, 16'h0100};
        vecs[5] = '{1'b1, 16'h7F7F, 16'h3F01};
        vecs[6] = '{1'b0, 16'h1234, 16'h03A8};
        vecs[7] = '{1'b1, 16'hFF01, 16'h00FF};
        seq1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        seq2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // ---------------- instance A: BURST=1, CNT_W=16 ----------------
        act = 1'b0; m_burst = 1; cmask = 65535;
        do_reset();
        check_reset("rst_a");

        // Single entry: RD pulse, then write 4 cycles after the grant
        lat = 1;
        load(0, 16'h0304, 16'h000C);
        prep();
        oafull = 1'b0;
        t = 0;
        while (!rd0 && t < 20) begin @(negedge CLK); t++; end
        check("lat_rd0_seen", 32'(rd0), 1);
        check("lat_rd1_quiet", 32'(rd1), 0);
        r = cyc;
        @(negedge CLK);
        check("lat_rd_width", 32'(rd0), 0);
        t = 0;
        while (!wr && t < 20) begin @(negedge CLK); t++; end
        w = cyc;
        check("lat_wr_seen", 32'(wr), 1);
        check("lat_wr_delay", w - r, 3);
        check("lat_cnt0", 32'(cnt0), 1);
        finish_batch();

        // Product table
        for (int i = 0; i < 8; i++) begin
            load(int'(vecs[i].src), vecs[i].din, vecs[i].dout);
            prep();
            finish_batch();
        end

        // Contention order with BURST=1
        tag_log.delete();
        for (int i = 0; i < 3; i++) begin d = 16'($urandom); load(0, d, prod(d)); end
        for (int i = 0; i < 3; i++) begin d = 16'($urandom); load(1, d, prod(d)); end
        prep();
        finish_batch();
        check("b1_seq_len", 32'(tag_log.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < tag_log.size()) check("b1_seq", 32'(tag_log[i]), 32'(seq1[i]));

        // OAFULL in IDLE blocks reads; OFULL in WRITE stalls the write
        ofull_force = 1'b1;
        load(1, 16'h1234, 16'h03A8);
        prep();
        any_rd = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge CLK); any_rd = any_rd | rd0 | rd1; end
        check("oafull_no_rd", 32'(any_rd), 0);
        oafull = 1'b0;
        t = 0;
        while (!rd1 && t < 20) begin @(negedge CLK); t++; end
        check("ofull_rd1_seen", 32'(rd1), 1);
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            check("ofull_wr_held", 32'(wr), 0);
            check("ofull_dout_stable", 32'(dout), 32'h03A8);
            @(negedge CLK);
        end
        ofull_force = 1'b0;
        t = 0;
        while (!wr && t < 10) begin @(negedge CLK); t++; end
        check("ofull_wr_after", 32'(wr), 1);
        @(negedge CLK);
        check("ofull_wr_single", 32'(wr), 0);
        finish_batch();

        // VALID never returns: ERR after 4 WAITV cycles, nothing written
        lat = 0;
        fifo_push(0, 16'h0505);
        model_grant(1'b1, 1'b0, t);
        oafull = 1'b0;
        t = 0;
        while (!rd0 && t < 20) begin @(negedge CLK); t++; end
        check("to_rd0_seen", 32'(rd0), 1);
        repeat (4) @(negedge CLK);
        check("to_err_early", 32'(err), 0);
        @(negedge CLK);
        check("to_err_set", 32'(err), 1);
        oafull = 1'b1;
        check("to_cnt0", 32'(cnt0), 32'(m_cnt0 & cmask));
        check("to_cnt1", 32'(cnt1), 32'(m_cnt1 & cmask));
        lat = 1;
        load(0, 16'h0A0B, 16'h006E);
        prep();
        finish_batch();
        check("to_err_sticky", 32'(err), 1);

        // Randomized batches with random VALID latency, OFULL and stray VALIDs
        for (int k = 0; k < 10; k++) rand_batch();

        // Reset during WAITV discards the in-flight read
        lat = 3;
        fifo_push(0, 16'h0F0F);
        oafull = 1'b0;
        t = 0;
        while (!rd0 && t < 20) begin @(negedge CLK); t++; end
        check("rw_rd0_seen", 32'(rd0), 1);
        oafull = 1'b1;
        @(negedge CLK);
        rst0 = 1'b1;
        @(negedge CLK);
        check_reset("rst_waitv");
        rst0 = 1'b0;
        m_last = -1; m_run = 0; m_cnt0 = 0; m_cnt1 = 0;
        repeat (6) @(negedge CLK);
        check("rw_no_wr_after", 32'(wr), 0);
        lat = 1;

        // ---------------- instance B: BURST=2, CNT_W=4 ----------------
        rst0 = 1'b1;
        act = 1'b1; m_burst = 2; cmask = 15;
        do_reset();
        check_reset("rst_b");

        tag_log.delete();
        for (int i = 0; i < 3; i++) begin d = 16'($urandom); load(0, d, prod(d)); end
        for (int i = 0; i < 3; i++) begin d = 16'($urandom); load(1, d, prod(d)); end
        prep();
        finish_batch();
        check("b2_seq_len", 32'(tag_log.size()), 6);
        for (int i = 0; i < 6; i++)
            if (i < tag_log.size()) check("b2_seq", 32'(tag_log[i]), 32'(seq2[i]));

        for (int k = 0; k < 6; k++) rand_batch();

        // Counter wrap: 17 results from source 1 on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin d = 16'($urandom); load(1, d, prod(d)); end
        prep();
        finish_batch();
        check("wrap_cnt1", 32'(cnt1), 1);
        check("wrap_cnt0", 32'(cnt0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter BURST, default 1: maximum consecutive grants to one source while the other source is requesting (1..15).
REQ-002 SHALL have parameter CNT_W, default 16: width of the per-source result counters.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports EMPTY0/EMPTY1  input  1  empty flag of source FIFO 0/1.
REQ-006 SHALL have ports VALID0/VALID1  input  1  read-data-valid from source FIFO 0/1.
REQ-007 SHALL have ports DIN0/DIN1  input  16  read data of source FIFO 0/1; [15:8] operand a, [7:0] operand b.
REQ-008 SHALL have ports RD0/RD1  output  1  registered read strobe to source FIFO 0/1.
REQ-009 SHALL have port OFULL  input  1  FULL of the result FIFO.
REQ-010 SHALL have port OAFULL  input  1  almostFULL of the result FIFO.
REQ-011 SHALL have port WR_OUT  output  1  registered write strobe to the result FIFO.
REQ-012 SHALL have port DOUT  output  16  registered product, valid while WR_OUT=1.
REQ-013 SHALL have port TAG  output  1  source index of DOUT, valid while WR_OUT=1.
REQ-014 SHALL have ports CNT0/CNT1  output  CNT_W  results written per source.
REQ-015 SHALL have port ERR  output  1  sticky VALID-timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, RDREQ, WAITV, WRITE.
REQ-017 Source x SHALL be eligible in IDLE when EMPTYx=0 and OAFULL=0; with no eligible source the FSM SHALL stay in IDLE.
REQ-018 Arbitration: one eligible source -> grant it; both eligible -> grant the last-granted source unless its consecutive-grant count equals BURST, in which case grant the other.
REQ-019 Consecutive-grant count SHALL reset to 1 on switching source, increment on repeating the same source, and saturate at BURST.
REQ-020 First arbitration after reset with both eligible SHALL grant source 0.
REQ-021 IDLE->RDREQ on grant; RDg SHALL be 1 for exactly the one RDREQ cycle; the other RD SHALL stay 0.
REQ-022 RDREQ->WAITV unconditionally.
REQ-023 In WAITV, when VALIDg=1, SHALL capture DINg[15:8]*DINg[7:0] (unsigned, full 16-bit, no truncation) into DOUT and g into TAG, then go to WRITE.
REQ-024 In WAITV, VALID of the non-granted source SHALL be ignored.
REQ-025 If VALIDg is not seen within 4 WAITV cycles, SHALL set ERR=1, write nothing and return to IDLE.
REQ-026 In WRITE, if OFULL=0, SHALL assert WR_OUT for exactly one cycle, increment CNTg (wrapping modulo 2^CNT_W) and return to IDLE.
REQ-027 In WRITE, if OFULL=1, SHALL hold WR_OUT=0 and keep DOUT/TAG stable until OFULL=0.
REQ-028 At most one read SHALL be in flight; minimum issue interval 4 cycles per result.
REQ-029 WR_OUT and RDx SHALL never be asserted in the same cycle.
REQ-030 EMPTYx/OAFULL changes outside IDLE SHALL not affect the transaction in progress.

Reset
REQ-031 On RST=1, at the clock edge: FSM=IDLE, RD0=RD1=0, WR_OUT=0, DOUT=0, TAG=0, CNT0=CNT1=0, ERR=0, last-granted=1, grant count=0.
REQ-032 RST SHALL take priority over every transition, including mid-WAITV or mid-WRITE; an in-flight result SHALL be discarded.

Verification
REQ-033 FIFO0 holds 0x0304, FIFO1 empty, OFULL=OAFULL=0 -> RD0 pulse, WR_OUT=1 with DOUT=0x000C, TAG=0, CNT0=1, 4 cycles after grant.
REQ-034 Both FIFOs hold 3 entries, BURST=1 -> TAG sequence 0,1,0,1,0,1; BURST=2 -> 0,0,1,1,0,1.
REQ-035 Input 0xFFFF -> DOUT=0xFE01; input 0x00FF -> DOUT=0x0000.
REQ-036 OFULL=1 held 5 cycles in WRITE -> WR_OUT stays 0, DOUT stable; one WR_OUT pulse after OFULL falls; OAFULL=1 in IDLE -> no RD issued.
REQ-037 VALIDg withheld after RD pulse -> ERR=1 after 4 WAITV cycles, no WR_OUT, CNTs unchanged, next grant proceeds normally.
REQ-038 RST asserted during WAITV -> next cycle all outputs at reset values, no WR_OUT; CNT_W=4 with 17 writes from source 1 -> CNT1=1.
